afifo_push_arbiter: RTL and testbench
=====================================

// Module: afifo_push_arbiter
//
// PURPOSE
//  Shares the write (PUSH/DIN) side of one BRAM18K async FIFO between N requesters
//  in the clock0 domain. Round-robin arbitration with flag-based backpressure.
//  Owns the FIFO's Async_Flush sequencing: automatic after reset, on request afterwards.
//  Sits between requester logic and the afNNNNxW_NNNNxW FIFO wrappers.
//
// PARAMETERS
//  N_REQ          4    number of requesters (2..8)
//  DATA_WIDTH     18   FIFO write width (18/16/9/8)
//  FLUSH_CYCLES   4    cycles Async_Flush is held high per flush
//  RECOVER_CYCLES 4    post-flush quiet cycles before pushes resume
//  BURST_LEN      8    max consecutive grants per requester (burst build only)
//
// PORTS
//  clock0             in   1               write-domain clock
//  reset              in   1               synchronous, active-high reset
//  req_valid          in   N_REQ           per-requester word valid
//  req_data           in   N_REQ*DATA_WIDTH  packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready          out  N_REQ           one-hot accept; transfer = valid & ready
//  flush_req          in   1               one-cycle pulse: start flush sequence
//  flush_busy         out  1               high while FIFO is flushing or recovering
//  grant_id           out  $clog2(N_REQ)   requester index of the last transfer
//  fifo_din           out  DATA_WIDTH      to FIFO DIN
//  fifo_push          out  1               to FIFO PUSH
//  fifo_flush         out  1               to FIFO Async_Flush
//  fifo_full          in   1               from FIFO Full
//  fifo_almost_full   in   1               from FIFO Almost_Full
//  fifo_overrun       in   1               from FIFO Overrun_Error
//  overrun_cnt        out  16              saturating count of overrun cycles
//
// BEHAVIOUR
//  - FSM: FLUSH -> RECOVER -> IDLE. Reset forces FLUSH with cycle counter 0.
//    * FLUSH: fifo_flush=1 for FLUSH_CYCLES cycles.
//    * RECOVER: fifo_flush=0 for RECOVER_CYCLES cycles.
//    * IDLE: arbitration enabled. flush_req in IDLE -> FLUSH next cycle.
//    * flush_req in FLUSH/RECOVER is ignored (no restart, no queueing).
//  - Reset values: fifo_flush=1, flush_busy=1, fifo_push=0, fifo_din=0, req_ready=0,
//    grant_id=0, overrun_cnt=0, round-robin pointer=0.
//  - flush_busy = (state != IDLE). req_ready is all-zero whenever flush_busy=1.
//  - Push-accept condition:
//    can_push = IDLE & !fifo_full & !(fifo_almost_full & fifo_push).
//    When almost full, at most one push is in flight, covering the flag latency.
//  - Arbitration: req_ready is combinational from req_valid, pointer and can_push.
//    The grant goes to the first valid requester at or after the pointer, modulo N_REQ.
//  - On a transfer by requester i:
//    * fifo_push=1 and fifo_din=req_data[i] on the next cycle (1-cycle latency).
//    * grant_id<=i.
//    * pointer <= (i+1) mod N_REQ.
//  - No transfer: fifo_push=0; fifo_din and pointer hold.
//  - Sustained rate is 1 word/cycle while can_push=1.
//  - Reset mid-operation discards any registered push (fifo_push=0 next cycle) and restarts FLUSH.
//  - overrun_cnt increments on every cycle fifo_overrun=1 and saturates at 16'hFFFF.
//    It is cleared only by reset; a flush does not clear it.
//
// CONFIGURATION
//  AFIFO_ARB_BURST_EN defined:
//    - The granted requester keeps the grant while req_valid stays high.
//    - The grant is held for up to BURST_LEN consecutive transfers.
//    - The pointer advances only when the burst ends: valid drops, BURST_LEN is reached, or flush.
//    - A cycle with can_push=0 pauses the burst; it does not end it.
//  AFIFO_ARB_BURST_EN undefined:
//    - Pure per-word round-robin; BURST_LEN is unused.
//
// STRUCTURE
//  - Package afifo_arb_pkg holds:
//    * FSM state typedef (ST_FLUSH, ST_RECOVER, ST_IDLE).
//    * Counter width constant for the flush/recover counter.
//    * OVR_CNT_W=16.
//  - Sub-module rr_arbiter (N_REQ): combinational rotate-priority one-hot grant from req, pointer, en.
//  - Top level holds the FSM, push register, pointer/burst counter and overrun counter.
//
// TESTING
//  1 Reset 3 cycles, then release:
//    fifo_flush=1 for exactly 4 cycles, then 4 quiet cycles; first req_ready on cycle 9.
//  2 N_REQ=4, all valid continuously, FIFO empty:
//    grants 0,1,2,3,0,...; fifo_din carries requester data 1 cycle after each transfer.
//  3 Only req 2 valid:
//    pushes every cycle (100% rate); grant_id=2 throughout.
//  4 Force fifo_almost_full=1:
//    pushes alternate 1,0,1,0.
//  5 Force fifo_full=1:
//    req_ready=0 and no push. Release full: pushes resume next cycle, no word lost or duplicated.
//  6 flush_req mid-stream plus a second flush_req during RECOVER:
//    - single flush, all readies 0 for 8 cycles.
//    - fifo_overrun high for 3 cycles -> overrun_cnt=3.
//    - with AFIFO_ARB_BURST_EN, all valid: grants 0 x8, 1 x8, ...

Source files
------------

// File: rtl/afifo_arb_pkg.sv
// Shared types and constants for the async-FIFO push arbiter.
//   arb_state_e : flush sequencer states (flush -> recover -> idle)
//   PHASE_CNT_W : width of the flush/recover cycle counter
//   OVR_CNT_W   : width of the saturating overrun counter
package afifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH   = 2'd0,
    ST_RECOVER = 2'd1,
    ST_IDLE    = 2'd2
  } arb_state_e;

  // Covers FLUSH_CYCLES / RECOVER_CYCLES up to 256.
  localparam int unsigned PHASE_CNT_W = 8;
  localparam int unsigned OVR_CNT_W   = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter.
// The grant goes to the first asserted request at or after ptr_i, modulo N_REQ.
//   req_i     : request vector
//   ptr_i     : highest-priority index
//   en_i      : grant enable; no grant when low
//   gnt_o     : one-hot grant (all-zero when nothing granted)
//   gnt_idx_o : index of the granted request (0 when nothing granted)
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  input  logic                     en_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] gnt_idx_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % N_REQ);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/afifo_push_arbiter.sv
// Shares the write side of one async FIFO between N_REQ requesters in the clock0 domain.
// Round-robin arbitration with flag backpressure; owns the FIFO Async_Flush sequence
// (automatic after reset, on flush_req_i afterwards).
// Build option: define AFIFO_ARB_BURST_EN to let a requester hold the grant for up to
// BURST_LEN consecutive transfers while its valid stays high.
//   clock0_i / reset_i        : clock, synchronous active-high reset
//   req_valid_i/req_data_i    : per-requester words (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready_o               : one-hot accept; transfer = valid & ready
//   flush_req_i/flush_busy_o  : flush request pulse / flushing-or-recovering status
//   grant_id_o                : requester index of the last transfer
//   fifo_din_o/fifo_push_o    : FIFO write data / push (one cycle after the transfer)
//   fifo_flush_o              : FIFO Async_Flush
//   fifo_full_i/fifo_almost_full_i/fifo_overrun_i : FIFO status flags
//   overrun_cnt_o             : saturating count of overrun cycles
module afifo_push_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DATA_WIDTH     = 18,
  parameter int unsigned FLUSH_CYCLES   = 4,
  parameter int unsigned RECOVER_CYCLES = 4,
  parameter int unsigned BURST_LEN      = 8
) (
  input  logic                        clock0_i,
  input  logic                        reset_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic                        flush_req_i,
  output logic                        flush_busy_o,
  output logic [$clog2(N_REQ)-1:0]    grant_id_o,
  output logic [DATA_WIDTH-1:0]       fifo_din_o,
  output logic                        fifo_push_o,
  output logic                        fifo_flush_o,
  input  logic                        fifo_full_i,
  input  logic                        fifo_almost_full_i,
  input  logic                        fifo_overrun_i,
  output logic [OVR_CNT_W-1:0]        overrun_cnt_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  arb_state_e             state_q, state_d;
  logic [PHASE_CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic                   push_q;
  logic [DATA_WIDTH-1:0]  din_q;
  logic [IdxW-1:0]        gid_q;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [OVR_CNT_W-1:0]   ovr_cnt_q, ovr_cnt_d;

  logic                   flush_start;
  logic                   can_push;
  logic [N_REQ-1:0]       gnt;
  logic [IdxW-1:0]        gnt_idx;
  logic                   transfer;
  logic [DATA_WIDTH-1:0]  sel_data;

  function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] i);
    return (i == IdxW'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // flush_req is only honoured in idle; during flush/recover it is dropped.
  assign flush_start = (state_q == ST_IDLE) && flush_req_i;

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    unique case (state_q)
      ST_FLUSH: begin
        if (phase_cnt_q == PHASE_CNT_W'(FLUSH_CYCLES - 1)) begin
          state_d     = ST_RECOVER;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      ST_RECOVER: begin
        if (phase_cnt_q == PHASE_CNT_W'(RECOVER_CYCLES - 1)) begin
          state_d     = ST_IDLE;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (flush_start) begin
          state_d     = ST_FLUSH;
          phase_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_FLUSH;
        phase_cnt_d = '0;
      end
    endcase
  end

  // With almost-full set, allow only one push in flight to cover the flag latency.
  assign can_push = (state_q == ST_IDLE) && !fifo_full_i && !(fifo_almost_full_i && push_q);

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .en_i      (can_push),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign transfer    = |gnt;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef AFIFO_ARB_BURST_EN
  localparam int unsigned BurstW = $clog2(BURST_LEN + 1);

  // While a burst is active (burst_cnt_q != 0) ptr_q points at the burst owner, so the
  // owner keeps top priority; the pointer moves past it once the burst ends.
  logic [BurstW-1:0] burst_cnt_q, burst_cnt_d, burst_next;

  always_comb begin
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    burst_next  = '0;
    if (transfer) begin
      burst_next = (burst_cnt_q != '0 && gnt_idx == ptr_q) ? burst_cnt_q + 1'b1 : BurstW'(1);
      if (burst_next == BurstW'(BURST_LEN) || flush_start) begin
        ptr_d       = inc_idx(gnt_idx);
        burst_cnt_d = '0;
      end else begin
        ptr_d       = gnt_idx;
        burst_cnt_d = burst_next;
      end
    end else if (burst_cnt_q != '0 && (!req_valid_i[ptr_q] || flush_start)) begin
      // Owner dropped valid (or flush): burst over. A can_push stall alone keeps it alive.
      ptr_d       = inc_idx(ptr_q);
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clock0_i) begin
    if (reset_i) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = inc_idx(gnt_idx);
    end
  end
`endif

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (fifo_overrun_i && ovr_cnt_q != '1) begin
      ovr_cnt_d = ovr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock0_i) begin
    if (reset_i) begin
      state_q     <= ST_FLUSH;
      phase_cnt_q <= '0;
      push_q      <= 1'b0;
      din_q       <= '0;
      gid_q       <= '0;
      ptr_q       <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      push_q      <= transfer;
      if (transfer) begin
        din_q <= sel_data;
        gid_q <= gnt_idx;
      end
      ptr_q       <= ptr_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  assign fifo_flush_o  = (state_q == ST_FLUSH);
  assign flush_busy_o  = (state_q != ST_IDLE);
  assign fifo_push_o   = push_q;
  assign fifo_din_o    = din_q;
  assign grant_id_o    = gid_q;
  assign overrun_cnt_o = ovr_cnt_q;

endmodule

// File: tb/tb_afifo_push_arbiter.sv
module tb_afifo_push_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 18;
  localparam int unsigned FC = 4;
  localparam int unsigned RC = 4;
  localparam int unsigned BL = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            flush_req;
  logic            flush_busy;
  logic [1:0]      grant_id;
  logic [DW-1:0]   fifo_din;
  logic            fifo_push;
  logic            fifo_flush;
  logic            fifo_full;
  logic            fifo_almost_full;
  logic            fifo_overrun;
  logic [15:0]     overrun_cnt;

  always #5 clk = ~clk;

  afifo_push_arbiter #(
    .N_REQ          (N),
    .DATA_WIDTH     (DW),
    .FLUSH_CYCLES   (FC),
    .RECOVER_CYCLES (RC),
    .BURST_LEN      (BL)
  ) dut (
    .clock0_i           (clk),
    .reset_i            (reset),
    .req_valid_i        (req_valid),
    .req_data_i         (req_data),
    .req_ready_o        (req_ready),
    .flush_req_i        (flush_req),
    .flush_busy_o       (flush_busy),
    .grant_id_o         (grant_id),
    .fifo_din_o         (fifo_din),
    .fifo_push_o        (fifo_push),
    .fifo_flush_o       (fifo_flush),
    .fifo_full_i        (fifo_full),
    .fifo_almost_full_i (fifo_almost_full),
    .fifo_overrun_i     (fifo_overrun),
    .overrun_cnt_o      (overrun_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  // Reference model: m_t counts cycles since the flush sequence started (idle once it
  // reaches FC+RC); the rest is the spec-visible state of the write port.
  int          m_t;
  int          m_ptr;
  int          m_owner;
  int          m_gid;
  int          m_ovr;
  logic        m_push;
  logic [DW-1:0] m_din;
`ifdef AFIFO_ARB_BURST_EN
  int          m_run;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t     = 0;
    m_ptr   = 0;
    m_owner = -1;
    m_gid   = 0;
    m_ovr   = 0;
    m_push  = 1'b0;
    m_din   = '0;
`ifdef AFIFO_ARB_BURST_EN
    m_run   = 0;
`endif
  endtask

  task automatic run_cycle(input logic rst, input logic [N-1:0] v, input logic full,
                           input logic af, input logic ov, input logic freq);
    logic [N-1:0] exp_rdy;
    logic         can;
    logic         fstart;
    int           start;
    int           g;
    int           idx;
    @(posedge clk);
    #1;
    cyc++;
    reset            = rst;
    req_valid        = v;
    fifo_full        = full;
    fifo_almost_full = af;
    fifo_overrun     = ov;
    flush_req        = freq;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    #1;
    check_eq("fifo_flush", 32'(fifo_flush), 32'(m_t < FC));
    check_eq("flush_busy", 32'(flush_busy), 32'(m_t < FC + RC));
    check_eq("fifo_push", 32'(fifo_push), 32'(m_push));
    check_eq("fifo_din", 32'(fifo_din), 32'(m_din));
    check_eq("grant_id", 32'(grant_id), 32'(m_gid));
    check_eq("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
    can   = (m_t >= FC + RC) && !full && !(af && m_push);
    start = (m_owner >= 0) ? m_owner : m_ptr;
    g     = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        idx = (start + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (rst) begin
      model_reset();
    end else begin
      fstart = freq && (m_t >= FC + RC);
      if (g >= 0) begin
        m_push = 1'b1;
        m_din  = req_data[g*DW +: DW];
        m_gid  = g;
      end else begin
        m_push = 1'b0;
      end
`ifdef AFIFO_ARB_BURST_EN
      if (g >= 0) begin
        if (g == m_owner) m_run++;
        else begin
          m_owner = g;
          m_run   = 1;
        end
        if (m_run == BL || fstart) begin
          m_ptr   = (g + 1) % N;
          m_owner = -1;
          m_run   = 0;
        end
      end else if (m_owner >= 0 && (!v[m_owner] || fstart)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_run   = 0;
      end
`else
      if (g >= 0) m_ptr = (g + 1) % N;
`endif
      if (ov && m_ovr < 65535) m_ovr++;
      if (fstart) m_t = 0;
      else if (m_t < FC + RC) m_t++;
    end
  endtask

  initial begin
    int flush_len;
    int first_rdy;
    reset            = 1'b1;
    req_valid        = '0;
    req_data         = '0;
    flush_req        = 1'b0;
    fifo_full        = 1'b0;
    fifo_almost_full = 1'b0;
    fifo_overrun     = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset held 3 cycles, then the automatic flush/recover sequence.
    repeat (3) run_cycle(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    flush_len = 0;
    first_rdy = 0;
    for (int c = 1; c <= 12; c++) begin
      run_cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
      if (fifo_flush) flush_len++;
      if (req_ready != '0 && first_rdy == 0) first_rdy = c;
    end
    check_eq("flush_len", 32'(flush_len), 32'd4);
    check_eq("first_ready", 32'(first_rdy), 32'd9);

    // All valid, FIFO empty.
    repeat (20) run_cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    // Only requester 2 valid.
    repeat (10) run_cycle(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    // Almost full: pushes alternate.
    repeat (10) run_cycle(1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    // Full, then release.
    repeat (5) run_cycle(1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) run_cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    // Flush mid-stream, second request during recover, overrun for 3 cycles.
    run_cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) run_cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) run_cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ovr_cnt_3", 32'(overrun_cnt), 32'd3);
    repeat (30) run_cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      run_cycle(($urandom_range(0, 99) == 0),
                N'($urandom),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 39) == 0));
    end
    run_cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
